tile_window_streamer: RTL and testbench

TILE_WINDOW_STREAMER -- requirements
Module: tile_window_streamer

---
 rtl/tile_window_streamer_pkg.sv | 9 +
 rtl/tile_window_streamer_if.sv | 28 ++
 rtl/tile_window_select.sv | 21 ++
 rtl/tile_window_streamer.sv | 85 ++++++++
 tb/tb_tile_window_streamer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_window_streamer_pkg.sv
// tile_window_streamer_pkg: shared state enum, mode constants and default sizes
package tile_window_streamer_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
  localparam logic MODE_H = 1'b0;
  localparam logic MODE_V = 1'b1;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_TILE_DIM = 15;
  localparam int DEF_N_TAPS = 8;
endpackage

// File: rtl/tile_window_streamer_if.sv
// tile_window_streamer_if: pixel-in / window-out handshake bundle plus control
interface tile_window_streamer_if import tile_window_streamer_pkg::*; #(
  parameter int PIX_W = DEF_PIX_W,
  parameter int TILE_DIM = DEF_TILE_DIM,
  parameter int N_TAPS = DEF_N_TAPS
) ();
  localparam int CW = $clog2(TILE_DIM);
  logic flush;
  logic mode;
  logic in_valid;
  logic in_ready;
  logic [PIX_W-1:0] in_pix;
  logic out_valid;
  logic out_ready;
  logic [N_TAPS*PIX_W-1:0] out_win;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic out_last;
  logic done;
  modport master (
    output flush, mode, in_valid, in_pix, out_ready,
    input in_ready, out_valid, out_win, out_row, out_col, out_last, done
  );
  modport slave (
    input flush, mode, in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_win, out_row, out_col, out_last, done
  );
endinterface

// File: rtl/tile_window_select.sv
// tile_window_select: combinational tap mux, tile storage + (mode,row,col) -> window
module tile_window_select import tile_window_streamer_pkg::*; #(
  parameter int PIX_W = DEF_PIX_W,
  parameter int TILE_DIM = DEF_TILE_DIM,
  parameter int N_TAPS = DEF_N_TAPS,
  localparam int CW = $clog2(TILE_DIM)
) (
  input  logic [TILE_DIM-1:0][TILE_DIM-1:0][PIX_W-1:0] i_pix,
  input  logic                                         i_mode,
  input  logic [CW-1:0]                                i_row,
  input  logic [CW-1:0]                                i_col,
  output logic [N_TAPS*PIX_W-1:0]                      o_win
);
  for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
    logic [CW-1:0] w_r;
    logic [CW-1:0] w_c;
    assign w_r = i_row + ((i_mode == MODE_V) ? CW'(k) : '0);
    assign w_c = i_col + ((i_mode == MODE_V) ? '0 : CW'(k));
    assign o_win[k*PIX_W +: PIX_W] = i_pix[w_r][w_c];
  end
endmodule

// File: rtl/tile_window_streamer.sv
// tile_window_streamer: loads a square tile in raster order, then streams sliding windows
module tile_window_streamer import tile_window_streamer_pkg::*; #(
  parameter int PIX_W = DEF_PIX_W,
  parameter int TILE_DIM = DEF_TILE_DIM,
  parameter int N_TAPS = DEF_N_TAPS
) (
  input logic clk,
  input logic reset,
  tile_window_streamer_if.slave bus
);
  localparam int CW = $clog2(TILE_DIM);
  localparam logic [CW-1:0] M = CW'(TILE_DIM - 1);
  localparam logic [CW-1:0] L = CW'(TILE_DIM - N_TAPS);
  state_t r_state, w_next;
  logic r_mode, r_valid, r_last, r_done;
  logic [CW-1:0] r_lr, r_lc, r_wr, r_wc, r_orow, r_ocol, w_nwr, w_nwc;
  logic [TILE_DIM-1:0][TILE_DIM-1:0][PIX_W-1:0] r_pix;
  logic [N_TAPS*PIX_W-1:0] r_win, w_win;
  logic w_in_hs, w_out_hs, w_last_pix, w_load, w_wlast;
  assign w_in_hs = bus.in_valid && bus.in_ready;
  assign w_out_hs = r_valid && bus.out_ready;
  assign w_last_pix = w_in_hs && r_state == LOAD && r_lr == M && r_lc == M;
  assign w_load = w_last_pix || (w_out_hs && !r_last);
  // r_wr/r_wc point at the window to be loaded next, so the output stays registered
  always_comb begin
    w_wlast = (r_mode == MODE_H) ? (r_wr == M && r_wc == L) : (r_wr == L && r_wc == M);
    w_nwc = (r_mode == MODE_H) ? ((r_wc == L) ? '0 : r_wc + 1'b1) : ((r_wr == L) ? r_wc + 1'b1 : r_wc);
    w_nwr = (r_mode == MODE_H) ? ((r_wc == L) ? r_wr + 1'b1 : r_wr) : ((r_wr == L) ? '0 : r_wr + 1'b1);
  end
  tile_window_select #(.PIX_W(PIX_W), .TILE_DIM(TILE_DIM), .N_TAPS(N_TAPS)) u_sel (
    .i_pix(r_pix), .i_mode(r_mode), .i_row(r_wr), .i_col(r_wc), .o_win(w_win)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = bus.flush ? IDLE
           : (r_state == IDLE && w_in_hs) ? LOAD
           : w_last_pix ? STREAM
           : (w_out_hs && r_last) ? IDLE
           : r_state;
  end
  always_comb begin
    bus.in_ready = (r_state != STREAM);
  end
  always_ff @(posedge clk)
    if (w_in_hs && !bus.flush) r_pix[r_lr][r_lc] <= bus.in_pix;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {r_lr, r_lc, r_wr, r_wc, r_orow, r_ocol} <= '0;
      {r_mode, r_valid, r_last, r_done} <= '0;
      r_win <= '0;
    end else if (bus.flush) begin
      {r_lr, r_lc, r_wr, r_wc} <= '0;
      {r_valid, r_last, r_done} <= '0;
    end else begin
      r_done <= w_out_hs && r_last;
      r_valid <= w_load ? 1'b1 : (w_out_hs ? 1'b0 : r_valid);
      if (w_in_hs && r_state == IDLE) r_mode <= bus.mode;
      if (w_in_hs) begin
        r_lc <= (r_lc == M) ? '0 : r_lc + 1'b1;
        r_lr <= (r_lc == M) ? ((r_lr == M) ? '0 : r_lr + 1'b1) : r_lr;
      end
      if (w_load) begin
        r_win <= w_win;
        r_orow <= r_wr;
        r_ocol <= r_wc;
        r_last <= w_wlast;
        r_wr <= w_nwr;
        r_wc <= w_nwc;
      end
      if (w_out_hs && r_last) begin
        r_last <= 1'b0;
        r_wr <= '0;
        r_wc <= '0;
      end
    end
  end
  assign bus.out_valid = r_valid;
  assign bus.out_win = r_win;
  assign bus.out_row = r_orow;
  assign bus.out_col = r_ocol;
  assign bus.out_last = r_last;
  assign bus.done = r_done;
endmodule

// File: tb/tb_tile_window_streamer.sv
// tb_tile_window_streamer: randomized scenarios against a window-order reference model
module tb_tile_window_streamer;
  localparam int D = 15, N = 8, D2 = 11, N2 = 7;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  tile_window_streamer_if #(.PIX_W(8), .TILE_DIM(D), .N_TAPS(N)) bus ();
  tile_window_streamer_if #(.PIX_W(8), .TILE_DIM(D2), .N_TAPS(N2)) bus2 ();
  tile_window_streamer #(.PIX_W(8), .TILE_DIM(D), .N_TAPS(N)) dut (.clk(clk), .reset(reset), .bus(bus));
  tile_window_streamer #(.PIX_W(8), .TILE_DIM(D2), .N_TAPS(N2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int n_cmp = 0, n_err = 0;
  logic [7:0] tile [16][16];
  logic [63:0] exp_win[$], rx_win[$];
  int exp_row[$], exp_col[$], rx_row[$], rx_col[$];
  bit rx_last[$];
  int unstable, stream_cycles, in_stalls;
  bit timed_out, first_valid, done_seen, done_next, valid_after, ready_after;

  task automatic fill_tile(input bit rnd);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        tile[r][c] = rnd ? 8'($urandom) : {r[3:0], c[3:0]};
  endtask

  // expected windows straight from the tap and ordering rules
  task automatic build_exp(input int dim, input int taps, input bit m);
    int r, c;
    logic [63:0] w;
    exp_win.delete(); exp_row.delete(); exp_col.delete();
    for (int o = 0; o < dim; o++)
      for (int i = 0; i <= dim - taps; i++) begin
        r = m ? i : o;
        c = m ? o : i;
        w = '0;
        for (int k = 0; k < taps; k++) w[8*k +: 8] = tile[m ? r + k : r][m ? c : c + k];
        exp_win.push_back(w); exp_row.push_back(r); exp_col.push_back(c);
      end
  endtask

  task automatic load(input int npix, input bit m, input bit scramble);
    int i = 0, tries = 0;
    in_stalls = 0;
    bus.mode = m;
    while (i < npix && tries < 3000) begin
      @(negedge clk);
      tries++;
      if ($urandom_range(0, 99) < 15) begin
        bus.in_valid = 1'b0;
        continue;
      end
      bus.in_valid = 1'b1;
      bus.in_pix = tile[i / D][i % D];
      bus.mode = (i == 0 || !scramble) ? m : 1'($urandom);
      if (bus.in_ready) i++;
      else in_stalls++;
    end
    if (i < npix) in_stalls++;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int pct);
    logic [63:0] hw;
    logic [3:0] hr, hc;
    logic hl;
    bit hold = 1'b0;
    rx_win.delete(); rx_row.delete(); rx_col.delete(); rx_last.delete();
    unstable = 0; stream_cycles = 0; timed_out = 1'b1;
    done_seen = 1'b0; done_next = 1'b1; valid_after = 1'b1; ready_after = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (t == 0) first_valid = bus.out_valid;
      if (hold && (bus.out_win !== hw || bus.out_row !== hr || bus.out_col !== hc || bus.out_last !== hl)) unstable++;
      bus.out_ready = ($urandom_range(0, 99) < pct);
      hold = bus.out_valid && !bus.out_ready;
      hw = bus.out_win; hr = bus.out_row; hc = bus.out_col; hl = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        rx_win.push_back(bus.out_win); rx_row.push_back(int'(bus.out_row));
        rx_col.push_back(int'(bus.out_col)); rx_last.push_back(bus.out_last);
        if (bus.out_last || rx_win.size() >= 400) begin
          stream_cycles = t + 1;
          timed_out = 1'b0;
          @(negedge clk);
          done_seen = bus.done; valid_after = bus.out_valid; ready_after = bus.in_ready;
          bus.out_ready = 1'b0;
          @(negedge clk);
          done_next = bus.done;
          break;
        end
      end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if ({bus.out_valid, bus.out_last, bus.done} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got v/l/d=%b want 000", {bus.out_valid, bus.out_last, bus.done}); end
    n_cmp++; if ({bus.out_win, bus.out_row, bus.out_col} !== '0) begin n_err++; $display("FAIL reset_data: got win=%h row=%0d col=%0d want 0", bus.out_win, bus.out_row, bus.out_col); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_horizontal;
    fill_tile(1'b0);
    build_exp(D, N, 1'b0);
    load(D * D, 1'b0, 1'b0);
    collect(100);
    n_cmp++; if (in_stalls !== 0) begin n_err++; $display("FAIL h_load_ready: got %0d stalls want 0", in_stalls); end
    n_cmp++; if (first_valid !== 1'b1) begin n_err++; $display("FAIL h_first_valid: got %b want 1", first_valid); end
    n_cmp++; if (rx_win.size() !== 120) begin n_err++; $display("FAIL h_count: got %0d want 120", rx_win.size()); end
    n_cmp++; if (rx_win[0] !== 64'h0706050403020100 || rx_row[0] !== 0 || rx_col[0] !== 0) begin n_err++; $display("FAIL h_first: got %h (%0d,%0d) want 0706050403020100 (0,0)", rx_win[0], rx_row[0], rx_col[0]); end
    n_cmp++; if (rx_win[119] !== 64'hEEEDECEBEAE9E8E7 || rx_row[119] !== 14 || rx_col[119] !== 7 || rx_last[119] !== 1'b1) begin n_err++; $display("FAIL h_final: got %h (%0d,%0d) last=%b want EEEDECEBEAE9E8E7 (14,7) 1", rx_win[119], rx_row[119], rx_col[119], rx_last[119]); end
    for (int i = 0; i < rx_win.size() && i < exp_win.size(); i++) begin
      n_cmp++;
      if (rx_win[i] !== exp_win[i] || rx_row[i] !== exp_row[i] || rx_col[i] !== exp_col[i] || rx_last[i] !== (i == exp_win.size() - 1)) begin
        n_err++; $display("FAIL h_win[%0d]: got %h (%0d,%0d) last=%b want %h (%0d,%0d)", i, rx_win[i], rx_row[i], rx_col[i], rx_last[i], exp_win[i], exp_row[i], exp_col[i]);
      end
    end
    n_cmp++; if (stream_cycles !== 120) begin n_err++; $display("FAIL back_to_back: got %0d cycles want 120", stream_cycles); end
    n_cmp++; if ({done_seen, done_next, valid_after, ready_after} !== 4'b1001) begin n_err++; $display("FAIL h_done: got done/done+1/valid/in_ready=%b want 1001", {done_seen, done_next, valid_after, ready_after}); end
  endtask

  task automatic test_vertical;
    fill_tile(1'b0);
    build_exp(D, N, 1'b1);
    load(D * D, 1'b1, 1'b1);
    collect(100);
    n_cmp++; if (rx_win.size() !== 120) begin n_err++; $display("FAIL v_count: got %0d want 120", rx_win.size()); end
    n_cmp++; if (rx_win[0] !== 64'h7060504030201000 || rx_row[0] !== 0 || rx_col[0] !== 0) begin n_err++; $display("FAIL v_first: got %h (%0d,%0d) want 7060504030201000 (0,0)", rx_win[0], rx_row[0], rx_col[0]); end
    n_cmp++; if (rx_win[1] !== 64'h8070605040302010 || rx_row[1] !== 1 || rx_col[1] !== 0) begin n_err++; $display("FAIL v_second: got %h (%0d,%0d) want 8070605040302010 (1,0)", rx_win[1], rx_row[1], rx_col[1]); end
    n_cmp++; if (rx_win[119] !== 64'hEEDECEBEAE9E8E7E || rx_row[119] !== 7 || rx_col[119] !== 14 || rx_last[119] !== 1'b1) begin n_err++; $display("FAIL v_final: got %h (%0d,%0d) last=%b want EEDECEBEAE9E8E7E (7,14) 1", rx_win[119], rx_row[119], rx_col[119], rx_last[119]); end
    for (int i = 0; i < rx_win.size() && i < exp_win.size(); i++) begin
      n_cmp++;
      if (rx_win[i] !== exp_win[i] || rx_row[i] !== exp_row[i] || rx_col[i] !== exp_col[i] || rx_last[i] !== (i == exp_win.size() - 1)) begin
        n_err++; $display("FAIL v_win[%0d]: got %h (%0d,%0d) last=%b want %h (%0d,%0d)", i, rx_win[i], rx_row[i], rx_col[i], rx_last[i], exp_win[i], exp_row[i], exp_col[i]);
      end
    end
  endtask

  task automatic test_random_stall;
    bit m = 1'($urandom);
    fill_tile(1'b1);
    build_exp(D, N, m);
    load(D * D, m, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_pix = 8'($urandom);
    collect(50);
    bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_cmp++; if (rx_win.size() !== 120 || timed_out) begin n_err++; $display("FAIL stall_count: got %0d timeout=%b want 120", rx_win.size(), timed_out); end
    n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL stall_hold: got %0d changes while stalled want 0", unstable); end
    for (int i = 0; i < rx_win.size() && i < exp_win.size(); i++) begin
      n_cmp++;
      if (rx_win[i] !== exp_win[i] || rx_row[i] !== exp_row[i] || rx_col[i] !== exp_col[i] || rx_last[i] !== (i == exp_win.size() - 1)) begin
        n_err++; $display("FAIL stall_win[%0d]: got %h (%0d,%0d) last=%b want %h (%0d,%0d)", i, rx_win[i], rx_row[i], rx_col[i], rx_last[i], exp_win[i], exp_row[i], exp_col[i]);
      end
    end
  endtask

  task automatic test_flush;
    fill_tile(1'b1);
    load(D * D, 1'b0, 1'b0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    n_cmp++; if ({bus.out_valid, bus.done, bus.in_ready} !== 3'b001) begin n_err++; $display("FAIL flush_stream: got valid/done/in_ready=%b want 001", {bus.out_valid, bus.done, bus.in_ready}); end
    load(100, 1'b1, 1'b0);
    @(negedge clk);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pix = 8'hFF;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++; if ({bus.out_valid, bus.done, bus.in_ready} !== 3'b001) begin n_err++; $display("FAIL flush_load: got valid/done/in_ready=%b want 001", {bus.out_valid, bus.done, bus.in_ready}); end
    fill_tile(1'b1);
    build_exp(D, N, 1'b0);
    load(D * D, 1'b0, 1'b0);
    collect(80);
    n_cmp++; if (rx_win.size() !== 120) begin n_err++; $display("FAIL flush_count: got %0d want 120", rx_win.size()); end
    for (int i = 0; i < rx_win.size() && i < exp_win.size(); i++) begin
      n_cmp++;
      if (rx_win[i] !== exp_win[i] || rx_row[i] !== exp_row[i] || rx_col[i] !== exp_col[i] || rx_last[i] !== (i == exp_win.size() - 1)) begin
        n_err++; $display("FAIL flush_win[%0d]: got %h (%0d,%0d) last=%b want %h (%0d,%0d)", i, rx_win[i], rx_row[i], rx_col[i], rx_last[i], exp_win[i], exp_row[i], exp_col[i]);
      end
    end
  endtask

  task automatic test_async_reset;
    fill_tile(1'b1);
    load(D * D, 1'b1, 1'b0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({bus.out_valid, bus.in_ready, bus.done, bus.out_last} !== 4'b0100) begin n_err++; $display("FAIL async_reset: got valid/in_ready/done/last=%b want 0100", {bus.out_valid, bus.in_ready, bus.done, bus.out_last}); end
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    fill_tile(1'b1);
    build_exp(D, N, 1'b1);
    load(D * D, 1'b1, 1'b0);
    collect(70);
    n_cmp++; if (rx_win.size() !== 120) begin n_err++; $display("FAIL rst_count: got %0d want 120", rx_win.size()); end
    for (int i = 0; i < rx_win.size() && i < exp_win.size(); i++) begin
      n_cmp++;
      if (rx_win[i] !== exp_win[i] || rx_row[i] !== exp_row[i] || rx_col[i] !== exp_col[i] || rx_last[i] !== (i == exp_win.size() - 1)) begin
        n_err++; $display("FAIL rst_win[%0d]: got %h (%0d,%0d) last=%b want %h (%0d,%0d)", i, rx_win[i], rx_row[i], rx_col[i], rx_last[i], exp_win[i], exp_row[i], exp_col[i]);
      end
    end
  endtask

  task automatic test_small_params;
    logic [63:0] got[$];
    int gr[$], gc[$];
    bit gl[$];
    for (int m = 0; m < 2; m++) begin
      fill_tile(1'b1);
      build_exp(D2, N2, 1'(m));
      got.delete(); gr.delete(); gc.delete(); gl.delete();
      for (int i = 0; i < D2 * D2; i++) begin
        @(negedge clk);
        bus2.in_valid = 1'b1;
        bus2.in_pix = tile[i / D2][i % D2];
        bus2.mode = (i == 0) ? 1'(m) : 1'($urandom);
      end
      @(posedge clk);
      #1 bus2.in_valid = 1'b0;
      for (int t = 0; t < 2000 && (gl.size() == 0 || !gl[gl.size() - 1]) && got.size() < 200; t++) begin
        @(negedge clk);
        bus2.out_ready = ($urandom_range(0, 99) < 70);
        if (bus2.out_valid && bus2.out_ready) begin
          got.push_back(64'(bus2.out_win)); gr.push_back(int'(bus2.out_row));
          gc.push_back(int'(bus2.out_col)); gl.push_back(bus2.out_last);
        end
      end
      @(negedge clk);
      bus2.out_ready = 1'b0;
      n_cmp++; if (got.size() !== 55) begin n_err++; $display("FAIL small_count m=%0d: got %0d want 55", m, got.size()); end
      for (int i = 0; i < got.size() && i < exp_win.size(); i++) begin
        n_cmp++;
        if (got[i] !== exp_win[i] || gr[i] !== exp_row[i] || gc[i] !== exp_col[i] || gl[i] !== (i == exp_win.size() - 1)) begin
          n_err++; $display("FAIL small_win m=%0d [%0d]: got %h (%0d,%0d) last=%b want %h (%0d,%0d)", m, i, got[i], gr[i], gc[i], gl[i], exp_win[i], exp_row[i], exp_col[i]);
        end
      end
    end
  endtask

  initial begin
    bus.flush = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_pix = '0; bus.out_ready = 1'b0;
    bus2.flush = 1'b0; bus2.mode = 1'b0; bus2.in_valid = 1'b0; bus2.in_pix = '0; bus2.out_ready = 1'b0;
    test_reset();
    test_horizontal();
    test_vertical();
    test_random_stall();
    test_flush();
    test_async_reset();
    test_small_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
